// File: rtl/tmr_pkg.sv
// Shared definitions for the triple-modular-redundant voters: mode and lane-state
// encodings, lane indices and the per-bit majority function.
package tmr_pkg;

   typedef enum logic [1:0] {
      MODE_TMR      = 2'b00,
      MODE_DMR      = 2'b01,
      MODE_DEGRADED = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      LANE_OK      = 2'b00,
      LANE_SUSPECT = 2'b01,
      LANE_FAULTED = 2'b10
   } lane_state_e;

   localparam int LANE_A    = 0;
   localparam int LANE_B    = 1;
   localparam int LANE_C    = 2;
   localparam int NUM_LANES = 3;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (b & c) | (a & c);
   endfunction

endpackage

// File: rtl/tmr_lane_monitor.sv
// Per-lane persistence tracker: a lane is declared faulted after PERSIST
// consecutive mismatching samples and stays faulted until cleared or reset.
module tmr_lane_monitor
   import tmr_pkg::*;
#(
   parameter int PERSIST = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        mm,
   output lane_state_e state,
   output logic        faulted,
   output logic        faulted_nxt
);

   localparam int PC_W = $clog2(PERSIST + 1);
   localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(PERSIST);

   lane_state_e     state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pc_inc;

   assign pc_inc = pc_q + PC_W'(1);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (clr) begin
         state_d = LANE_OK;
         pc_d    = '0;
      end else begin
         case (state_q)
            LANE_OK: begin
               if (mm) begin
                  pc_d    = PC_W'(1);
                  state_d = (PERSIST == 1) ? LANE_FAULTED : LANE_SUSPECT;
               end
            end
            LANE_SUSPECT: begin
               if (mm) begin
                  pc_d = pc_inc;
                  if (pc_inc == PC_LIMIT) begin
                     state_d = LANE_FAULTED;
                  end
               end else begin
                  pc_d    = '0;
                  state_d = LANE_OK;
               end
            end
            LANE_FAULTED: begin
               state_d = LANE_FAULTED;
            end
            default: begin
               state_d = LANE_OK;
               pc_d    = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= LANE_OK;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign state       = state_q;
   assign faulted     = (state_q == LANE_FAULTED);
   assign faulted_nxt = (state_d == LANE_FAULTED);

endmodule

// File: rtl/tmr_gpio_voter_mon.sv
// Registered TMR GPIO voter with per-lane disagreement monitoring, fault masking
// (TMR -> DMR -> DEGRADED) and a saturating mismatch-event counter.
module tmr_gpio_voter_mon
   import tmr_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PERSIST = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gpio_a,
   input  logic [WIDTH-1:0] gpio_b,
   input  logic [WIDTH-1:0] gpio_c,
   input  logic             mask_en,
   input  logic             clr_faults,
   output logic [WIDTH-1:0] gpio_voted,
   output logic [2:0]       lane_mismatch,
   output logic [2:0]       lane_fault,
   output logic [1:0]       mode,
   output logic             unresolved,
   output logic [CNT_W-1:0] err_count
);

   logic [WIDTH-1:0] maj;
   logic [2:0]       mm;
   logic [2:0]       fault_nxt;
   lane_state_e      lane_state [NUM_LANES];

   logic [WIDTH-1:0] voted_q, voted_d;
   logic [2:0]       mm_q, mm_d;
   mode_e            mode_q, mode_d;
   logic             unres_q, unres_d;
   logic [CNT_W-1:0] err_q, err_d;

   logic [WIDTH-1:0] pair_x, pair_y, agree;
   logic [1:0]       fault_cnt;

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         maj[i] = maj3(gpio_a[i], gpio_b[i], gpio_c[i]);
      end
   end

   assign mm[LANE_A] = |(gpio_a ^ maj);
   assign mm[LANE_B] = |(gpio_b ^ maj);
   assign mm[LANE_C] = |(gpio_c ^ maj);

   tmr_lane_monitor #(.PERSIST(PERSIST)) u_mon_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr_faults),
      .mm          (mm[LANE_A]),
      .state       (lane_state[LANE_A]),
      .faulted     (lane_fault[LANE_A]),
      .faulted_nxt (fault_nxt[LANE_A])
   );

   tmr_lane_monitor #(.PERSIST(PERSIST)) u_mon_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr_faults),
      .mm          (mm[LANE_B]),
      .state       (lane_state[LANE_B]),
      .faulted     (lane_fault[LANE_B]),
      .faulted_nxt (fault_nxt[LANE_B])
   );

   tmr_lane_monitor #(.PERSIST(PERSIST)) u_mon_c (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr_faults),
      .mm          (mm[LANE_C]),
      .state       (lane_state[LANE_C]),
      .faulted     (lane_fault[LANE_C]),
      .faulted_nxt (fault_nxt[LANE_C])
   );

   // In DMR exactly one lane is faulted; the other two form the voting pair.
   always_comb begin
      pair_x = gpio_a;
      pair_y = gpio_b;
      if (lane_state[LANE_A] == LANE_FAULTED) begin
         pair_x = gpio_b;
         pair_y = gpio_c;
      end else if (lane_state[LANE_B] == LANE_FAULTED) begin
         pair_x = gpio_a;
         pair_y = gpio_c;
      end
   end

   assign agree     = ~(pair_x ^ pair_y);
   assign fault_cnt = 2'(fault_nxt[LANE_A]) + 2'(fault_nxt[LANE_B]) + 2'(fault_nxt[LANE_C]);

   always_comb begin
      voted_d = maj;
      unres_d = 1'b0;
      mm_d    = mm;
      err_d   = err_q;
      mode_d  = MODE_TMR;

      if (mode_q == MODE_DMR && mask_en && !clr_faults) begin
         voted_d = (pair_x & agree) | (voted_q & ~agree);
         unres_d = ~&agree;
      end

      case (fault_cnt)
         2'd0:    mode_d = MODE_TMR;
         2'd1:    mode_d = MODE_DMR;
         default: mode_d = MODE_DEGRADED;
      endcase

      if (clr_faults) begin
         mm_d  = '0;
         err_d = '0;
      end else if (|mm && err_q != {CNT_W{1'b1}}) begin
         err_d = err_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         voted_q <= '0;
         mm_q    <= '0;
         mode_q  <= MODE_TMR;
         unres_q <= 1'b0;
         err_q   <= '0;
      end else begin
         voted_q <= voted_d;
         mm_q    <= mm_d;
         mode_q  <= mode_d;
         unres_q <= unres_d;
         err_q   <= err_d;
      end
   end

   assign gpio_voted    = voted_q;
   assign lane_mismatch = mm_q;
   assign mode          = mode_q;
   assign unresolved    = unres_q;
   assign err_count     = err_q;

endmodule

// File: tb/tb_tmr_gpio_voter_mon.sv
// Scoreboard bench for tmr_gpio_voter_mon: directed vectors push hand-computed
// expectations, a monitor pops and compares one entry after every clock edge.
module tb_tmr_gpio_voter_mon;

   localparam int C_V   = 1;
   localparam int C_M   = 2;
   localparam int C_F   = 4;
   localparam int C_MO  = 8;
   localparam int C_U   = 16;
   localparam int C_E   = 32;
   localparam int C_E4  = 64;
   localparam int C_ALL = 63;

   typedef struct {
      logic [7:0] voted;
      logic [2:0] mm;
      logic [2:0] fault;
      logic [1:0] mode;
      logic       unres;
      logic [7:0] err;
      logic [3:0] err4;
      int         care;
   } exp_t;

   exp_t sb[$];
   int   nVectors;
   int   nMiscompares;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       rst2En = 1'b0;
   logic [7:0] gA = '0, gB = '0, gC = '0;
   logic       maskEn = 1'b1;
   logic       clr = 1'b0;

   logic [7:0] voted;
   logic [2:0] laneMm, laneFault;
   logic [1:0] modeOut;
   logic       unres;
   logic [7:0] errCnt;

   logic [7:0] voted4;
   logic [2:0] laneMm4, laneFault4;
   logic [1:0] mode4;
   logic       unres4;
   logic [3:0] errCnt4;

   always #5 clk = ~clk;

   tmr_gpio_voter_mon #(.WIDTH(8), .PERSIST(4), .CNT_W(8)) dut (
      .clk           (clk),
      .rst_n         (rstN),
      .gpio_a        (gA),
      .gpio_b        (gB),
      .gpio_c        (gC),
      .mask_en       (maskEn),
      .clr_faults    (clr),
      .gpio_voted    (voted),
      .lane_mismatch (laneMm),
      .lane_fault    (laneFault),
      .mode          (modeOut),
      .unresolved    (unres),
      .err_count     (errCnt)
   );

   tmr_gpio_voter_mon #(.WIDTH(8), .PERSIST(4), .CNT_W(4)) dut4 (
      .clk           (clk),
      .rst_n         (rstN & rst2En),
      .gpio_a        (gA),
      .gpio_b        (gB),
      .gpio_c        (gC),
      .mask_en       (maskEn),
      .clr_faults    (clr),
      .gpio_voted    (voted4),
      .lane_mismatch (laneMm4),
      .lane_fault    (laneFault4),
      .mode          (mode4),
      .unresolved    (unres4),
      .err_count     (errCnt4)
   );

   task automatic checkOutput(input string name, input int act, input int exp);
      if (act != exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic m, input logic cl,
                                input logic [7:0] eV, input logic [2:0] eM, input logic [2:0] eF,
                                input logic [1:0] eMo, input logic eU, input logic [7:0] eE,
                                input logic [3:0] eE4, input int care);
      exp_t e;
      @(negedge clk);
      rstN   = rst;
      gA     = a;
      gB     = b;
      gC     = c;
      maskEn = m;
      clr    = cl;
      e.voted = eV;
      e.mm    = eM;
      e.fault = eF;
      e.mode  = eMo;
      e.unres = eU;
      e.err   = eE;
      e.err4  = eE4;
      e.care  = care;
      sb.push_back(e);
   endtask

   // Each expectation describes the outputs right after the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            nVectors++;
            if ((e.care & C_V) != 0)  checkOutput("gpio_voted",    int'(voted),     int'(e.voted));
            if ((e.care & C_M) != 0)  checkOutput("lane_mismatch", int'(laneMm),    int'(e.mm));
            if ((e.care & C_F) != 0)  checkOutput("lane_fault",    int'(laneFault), int'(e.fault));
            if ((e.care & C_MO) != 0) checkOutput("mode",          int'(modeOut),   int'(e.mode));
            if ((e.care & C_U) != 0)  checkOutput("unresolved",    int'(unres),     int'(e.unres));
            if ((e.care & C_E) != 0)  checkOutput("err_count",     int'(errCnt),    int'(e.err));
            if ((e.care & C_E4) != 0) checkOutput("err_count_w4",  int'(errCnt4),   int'(e.err4));
         end
      end
   end

   initial begin
      int waitCycles;
      nVectors     = 0;
      nMiscompares = 0;

      // Reset with random lanes, then a clean sample
      applyStimulus(0, 8'($urandom), 8'($urandom), 8'($urandom), 1, 0, 8'h00, 3'b000, 3'b000, 2'b00, 0, 8'd0, 4'd0, C_ALL);
      applyStimulus(0, 8'($urandom), 8'($urandom), 8'($urandom), 1, 0, 8'h00, 3'b000, 3'b000, 2'b00, 0, 8'd0, 4'd0, C_ALL);
      applyStimulus(1, 8'hA5, 8'hA5, 8'hA5, 1, 0, 8'hA5, 3'b000, 3'b000, 2'b00, 0, 8'd0, 4'd0, C_ALL);
      applyStimulus(1, 8'hA5, 8'hA5, 8'hA5, 1, 0, 8'hA5, 3'b000, 3'b000, 2'b00, 0, 8'd0, 4'd0, C_ALL);

      // Lane B transient, three samples, recovers
      applyStimulus(1, 8'hA5, 8'hA4, 8'hA5, 1, 0, 8'hA5, 3'b010, 3'b000, 2'b00, 0, 8'd1, 4'd0, C_ALL);
      applyStimulus(1, 8'hA5, 8'hA4, 8'hA5, 1, 0, 8'hA5, 3'b010, 3'b000, 2'b00, 0, 8'd2, 4'd0, C_ALL);
      applyStimulus(1, 8'hA5, 8'hA4, 8'hA5, 1, 0, 8'hA5, 3'b010, 3'b000, 2'b00, 0, 8'd3, 4'd0, C_ALL);
      applyStimulus(1, 8'hA5, 8'hA5, 8'hA5, 1, 0, 8'hA5, 3'b000, 3'b000, 2'b00, 0, 8'd3, 4'd0, C_ALL);

      // Lane C persistent fault -> DMR, then masked voting
      applyStimulus(1, 8'hFF, 8'hFF, 8'h00, 1, 0, 8'hFF, 3'b100, 3'b000, 2'b00, 0, 8'd4, 4'd0, C_ALL);
      applyStimulus(1, 8'hFF, 8'hFF, 8'h00, 1, 0, 8'hFF, 3'b100, 3'b000, 2'b00, 0, 8'd5, 4'd0, C_ALL);
      applyStimulus(1, 8'hFF, 8'hFF, 8'h00, 1, 0, 8'hFF, 3'b100, 3'b000, 2'b00, 0, 8'd6, 4'd0, C_ALL);
      applyStimulus(1, 8'hFF, 8'hFF, 8'h00, 1, 0, 8'hFF, 3'b100, 3'b100, 2'b01, 0, 8'd7, 4'd0, C_ALL);
      applyStimulus(1, 8'hFF, 8'h0F, 8'hFF, 1, 0, 8'hFF, 3'b010, 3'b100, 2'b01, 1, 8'd8, 4'd0, C_ALL);
      applyStimulus(1, 8'hFF, 8'h0F, 8'hFF, 0, 0, 8'hFF, 3'b010, 3'b100, 2'b01, 0, 8'd9, 4'd0, C_ALL);
      applyStimulus(1, 8'hFF, 8'hFF, 8'hFF, 1, 0, 8'hFF, 3'b000, 3'b100, 2'b01, 0, 8'd9, 4'd0, C_ALL);

      // Lane B faults too -> DEGRADED, then raw majority
      applyStimulus(1, 8'h3C, 8'h00, 8'h3C, 1, 0, 8'h3C, 3'b010, 3'b100, 2'b01, 1, 8'd10, 4'd0, C_ALL);
      applyStimulus(1, 8'h3C, 8'h00, 8'h3C, 1, 0, 8'h3C, 3'b010, 3'b100, 2'b01, 1, 8'd11, 4'd0, C_ALL);
      applyStimulus(1, 8'h3C, 8'h00, 8'h3C, 1, 0, 8'h3C, 3'b010, 3'b100, 2'b01, 1, 8'd12, 4'd0, C_ALL);
      applyStimulus(1, 8'h3C, 8'h00, 8'h3C, 1, 0, 8'h3C, 3'b010, 3'b110, 2'b10, 1, 8'd13, 4'd0, C_ALL);
      applyStimulus(1, 8'h3C, 8'h00, 8'h3C, 1, 0, 8'h3C, 3'b010, 3'b110, 2'b10, 0, 8'd14, 4'd0, C_ALL);
      applyStimulus(1, 8'h81, 8'h00, 8'h81, 1, 0, 8'h81, 3'b010, 3'b110, 2'b10, 0, 8'd15, 4'd0, C_ALL);

      // Build fault C with err_count = 7, then clear on a mismatching sample
      applyStimulus(0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 3'b000, 3'b000, 2'b00, 0, 8'd0, 4'd0, C_ALL);
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1, 8'hFF, 8'hFF, 8'h00, 1, 0, 8'hFF, 3'b100,
                       (k >= 4) ? 3'b100 : 3'b000, (k >= 4) ? 2'b01 : 2'b00,
                       0, 8'(k), 4'd0, C_ALL);
      end
      applyStimulus(1, 8'hFF, 8'hFF, 8'h00, 1, 1, 8'hFF, 3'b000, 3'b000, 2'b00, 0, 8'd0, 4'd0, C_ALL);
      applyStimulus(1, 8'hFF, 8'hFF, 8'hFF, 1, 0, 8'hFF, 3'b000, 3'b000, 2'b00, 0, 8'd0, 4'd0, C_ALL);

      // Saturation on the 4-bit counter instance
      rst2En = 1'b1;
      applyStimulus(0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 3'b000, 3'b000, 2'b00, 0, 8'd0, 4'd0, C_ALL | C_E4);
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(1, 8'hA5, 8'h5A, 8'hA5, 1, 0, 8'hA5, 3'b010,
                       (k >= 4) ? 3'b010 : 3'b000, (k >= 4) ? 2'b01 : 2'b00,
                       0, 8'(k), (k > 15) ? 4'd15 : 4'(k), C_ALL | C_E4);
      end

      // Reset mid-SUSPECT clears persistence
      applyStimulus(0, 8'hA5, 8'h5A, 8'hA5, 1, 0, 8'h00, 3'b000, 3'b000, 2'b00, 0, 8'd0, 4'd0, C_ALL | C_E4);
      applyStimulus(1, 8'hA5, 8'h5A, 8'hA5, 1, 0, 8'hA5, 3'b010, 3'b000, 2'b00, 0, 8'd1, 4'd1, C_ALL | C_E4);
      applyStimulus(1, 8'hA5, 8'h5A, 8'hA5, 1, 0, 8'hA5, 3'b010, 3'b000, 2'b00, 0, 8'd2, 4'd2, C_ALL | C_E4);
      applyStimulus(0, 8'hA5, 8'h5A, 8'hA5, 1, 0, 8'h00, 3'b000, 3'b000, 2'b00, 0, 8'd0, 4'd0, C_ALL | C_E4);
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1, 8'hA5, 8'h5A, 8'hA5, 1, 0, 8'hA5, 3'b010, 3'b000, 2'b00, 0, 8'(k), 4'(k), C_ALL | C_E4);
      end
      applyStimulus(1, 8'hA5, 8'hA5, 8'hA5, 1, 0, 8'hA5, 3'b000, 3'b000, 2'b00, 0, 8'd3, 4'd3, C_ALL | C_E4);
      applyStimulus(1, 8'hA5, 8'h5A, 8'hA5, 1, 0, 8'hA5, 3'b010, 3'b000, 2'b00, 0, 8'd4, 4'd4, C_ALL | C_E4);

      waitCycles = 0;
      while (sb.size() > 0 && waitCycles < 20) begin
         @(posedge clk);
         waitCycles++;
      end
      #2;
      if (sb.size() > 0) begin
         nMiscompares++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/tmr_gpio_voter_mon.md
Name: tmr_gpio_voter_mon

Overview:
- Registered, parametrised successor to the plain bit-wise TMR GPIO voter for the MI-V triple-redundant PolarFire design.
- Votes three WIDTH-bit GPIO output buses and monitors each lane for disagreement with the majority.
- Declares a lane faulted after PERSIST consecutive mismatching cycles, then masks it (TMR → DMR → DEGRADED).
- Reports status and saturating error counts to the TMR supervisor.

Parameters:
- WIDTH, 8: GPIO bus width; ≥1.
- PERSIST, 4: consecutive mismatching samples before a lane is declared faulted; ≥1.
- CNT_W, 8: width of the saturating mismatch-event counter; ≥1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- gpio_a  in  WIDTH  lane A GPIO outputs.
- gpio_b  in  WIDTH  lane B GPIO outputs.
- gpio_c  in  WIDTH  lane C GPIO outputs.
- mask_en  in  1  1 = exclude faulted lanes from voting; 0 = always plain 2-of-3.
- clr_faults  in  1  clears faults, counters and mode.
- gpio_voted  out  WIDTH  registered voted outputs.
- lane_mismatch  out  3  registered per-lane mismatch of the previous sample; bit0 = A, bit1 = B, bit2 = C.
- lane_fault  out  3  sticky per-lane fault flags.
- mode  out  2  00 TMR, 01 DMR, 10 DEGRADED.
- unresolved  out  1  registered: DMR healthy lanes disagreed on ≥1 bit in the previous sample.
- err_count  out  CNT_W  saturating count of samples with any lane mismatch.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low.
  - rst_n = 0 at a rising edge forces all outputs and internal state to 0 (mode = TMR).
  - Reset overrides clr_faults and all other inputs, including mid-persistence.
- Raw majority: maj = (a&b)|(b&c)|(a&c), per bit. Lane X mismatch: mm_X = |(X ^ maj).
- Voting, sampled each edge; latency 1 cycle:
  - TMR mode, or mask_en = 0: gpio_voted <= maj.
  - DMR mode with mask_en = 1: use the two healthy lanes, per bit.
    - Where they agree, take their value.
    - Where they differ, hold the previous gpio_voted bit and set unresolved for one cycle.
  - DEGRADED mode: gpio_voted <= maj. No correction is possible; the supervisor acts on mode.
- Monitoring always uses maj, in every mode.
  - lane_mismatch <= {mm_c, mm_b, mm_a}.
  - err_count increments when any mm_X = 1 and saturates at 2^CNT_W-1.
- Per-lane state machine, one instance per lane, with persistence counter pc (width clog2(PERSIST+1)):
  - OK: on mm, pc = 1. If PERSIST = 1, go directly to FAULTED; else go to SUSPECT.
  - SUSPECT:
    - On mm, pc++. When pc reaches PERSIST, go to FAULTED.
    - On a matching sample, pc = 0 and return to OK.
  - FAULTED: sticky. Only clr_faults or reset leaves it. mm is still counted in err_count.
  - lane_fault[X] = (state == FAULTED). It rises at the edge that samples the PERSIST-th consecutive mismatch.
- Mode is derived from the next-state fault count and registered with lane_fault: 0 faults → TMR, 1 → DMR, ≥2 → DEGRADED.
  - Masking therefore applies starting with the sample after the fault edge.
- clr_faults = 1 at an edge:
  - Lanes go to OK, pc = 0, err_count = 0, mode = TMR, lane_mismatch = 0, unresolved = 0.
  - The mismatch sampled in that cycle is discarded.
  - gpio_voted <= maj; voting is not interrupted.
- Simultaneous faults: if two lanes reach PERSIST on the same edge, mode goes TMR → DEGRADED directly.
- Benign disagreement: distinct bits wrong in different lanes still produce a correct per-bit maj; each lane with a wrong bit flags mm.

Decomposition:
- Shared package tmr_pkg holds:
  - mode encodings MODE_TMR, MODE_DMR, MODE_DEGRADED.
  - lane state encodings LANE_OK, LANE_SUSPECT, LANE_FAULTED.
  - lane index constants.
  - a maj3 function, reusable by other TMR voters.
- Sub-module tmr_lane_monitor (params PERSIST):
  - inputs clk, rst_n, clr, mm; outputs state and faulted.
  - instantiated three times.
- Top level holds the voter datapath, mode register and err_count.

Test Plan (WIDTH = 8, PERSIST = 4, CNT_W = 8 unless noted):
1. rst_n = 0 for 2 cycles with random lanes → gpio_voted = 0x00, lane_fault = 000, mode = 00, err_count = 0. Then a = b = c = 0xA5 → gpio_voted = 0xA5 one cycle after sampling, lane_mismatch = 000.
2. a = c = 0xA5, b = 0xA4 for 3 cycles, then 0xA5 → gpio_voted stays 0xA5, lane_mismatch[1] high 3 cycles, err_count = 3, lane_fault = 000 (B back to OK).
3. a = b = 0xFF, c = 0x00 for 4 cycles → lane_fault = 100, mode = 01. Then a = 0xFF, b = 0x0F, c = 0xFF with mask_en = 1 → gpio_voted = 0xFF (bits 7:4 held), unresolved = 1. Repeat with mask_en = 0 → gpio_voted = 0xFF via maj, unresolved = 0.
4. Fault C as in 3, then b = 0x00 for 4 cycles with a = c = 0x3C → lane_fault = 110, mode = 10, gpio_voted follows raw maj.
5. clr_faults = 1 on the same edge as a mismatching sample, with lane_fault = 100 and err_count = 7 → next cycle lane_fault = 000, mode = 00, err_count = 0, lane_mismatch = 000.
6. CNT_W = 4, b mismatching for 20 cycles → err_count saturates at 15 and stays. rst_n = 0 asserted mid-SUSPECT (pc = 2) → pc = 0; a later 3-cycle mismatch does not fault.
